// File: rtl/kbd_display.sv
// PS/2 set-2 key tracker: follows make/break/extended prefixes, counts distinct presses in BCD,
// maps the held key to ASCII and drives six active-low seven-segment digits.
module kbd_display (
    input  logic       clk,
    input  logic       rst,
    input  logic       code_valid_i,
    input  logic [7:0] code_i,
    output logic       key_held_o,
    output logic [7:0] ascii_o,
    output logic [7:0] press_count_o,
    output logic [6:0] seg_code_lo_o,
    output logic [6:0] seg_code_hi_o,
    output logic [6:0] seg_ascii_lo_o,
    output logic [6:0] seg_ascii_hi_o,
    output logic [6:0] seg_cnt_lo_o,
    output logic [6:0] seg_cnt_hi_o
);

    typedef enum logic [1:0] {StIdle, StHeld, StBrk} state_e;

    localparam logic [6:0] SegBlank = 7'h7F;

    state_e     state_q, state_d;
    state_e     brk_from_q, brk_from_d;
    logic       ext_q, ext_d;
    logic [8:0] held_q, held_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] ascii_q, ascii_d;
    logic [8:0] key;
    logic       cnt_inc;
    logic       held_next;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] ascii_map(input logic [7:0] c);
        logic [7:0] a;
        case (c)
            8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
            8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
            8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
            8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
            8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
            8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = 8'h20; 8'h5A: a = 8'h0D;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] != 4'd9) begin
            r = {v[7:4], v[3:0] + 4'd1};
        end else if (v[7:4] != 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = 8'h00;
        end
        return r;
    endfunction

    assign key = {ext_q, code_i};

    always_comb begin
        state_d    = state_q;
        brk_from_d = brk_from_q;
        ext_d      = ext_q;
        held_d     = held_q;
        cnt_inc    = 1'b0;
        if (code_valid_i) begin
            if (code_i == 8'hE0) begin
                ext_d = 1'b1;
            end else if (code_i == 8'hF0) begin
                // A repeated F0 must not overwrite the state we return to.
                if (state_q != StBrk) begin
                    brk_from_d = state_q;
                    state_d    = StBrk;
                end
            end else if (code_i == 8'h00 || code_i == 8'hFA || code_i == 8'hAA) begin
                state_d = state_q;
            end else begin
                ext_d = 1'b0;
                case (state_q)
                    StIdle: begin
                        held_d  = key;
                        state_d = StHeld;
                        cnt_inc = 1'b1;
                    end
                    StHeld: begin
                        if (key != held_q) begin
                            held_d  = key;
                            cnt_inc = 1'b1;
                        end
                    end
                    StBrk: begin
                        if (key == held_q && brk_from_q == StHeld) begin
                            state_d = StIdle;
                        end else begin
                            state_d = brk_from_q;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
        cnt_d     = cnt_inc ? bcd_inc(cnt_q) : cnt_q;
        held_next = (state_d == StHeld) || (state_d == StBrk && brk_from_d == StHeld);
        ascii_d   = (held_next && !held_d[8]) ? ascii_map(held_d[7:0]) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            brk_from_q <= StIdle;
            ext_q      <= 1'b0;
            held_q     <= 9'h000;
            cnt_q      <= 8'h00;
            ascii_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            brk_from_q <= brk_from_d;
            ext_q      <= ext_d;
            held_q     <= held_d;
            cnt_q      <= cnt_d;
            ascii_q    <= ascii_d;
        end
    end

    // A pending break does not release the key until the matching code arrives.
    assign key_held_o    = (state_q == StHeld) || (state_q == StBrk && brk_from_q == StHeld);
    assign ascii_o       = ascii_q;
    assign press_count_o = cnt_q;

    assign seg_code_lo_o  = key_held_o ? hex_seg(held_q[3:0]) : SegBlank;
    assign seg_code_hi_o  = key_held_o ? hex_seg(held_q[7:4]) : SegBlank;
    assign seg_ascii_lo_o = key_held_o ? hex_seg(ascii_q[3:0]) : SegBlank;
    assign seg_ascii_hi_o = key_held_o ? hex_seg(ascii_q[7:4]) : SegBlank;
    assign seg_cnt_lo_o   = hex_seg(cnt_q[3:0]);
    assign seg_cnt_hi_o   = hex_seg(cnt_q[7:4]);

endmodule

// File: tb/tb_kbd_display.sv
// Scoreboard bench for kbd_display: each strobe or reset pushes the expected outputs, and a
// monitor pops and compares one cycle later.
module tb_kbd_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       code_valid = 1'b0;
    logic [7:0] code = 8'h00;
    logic       key_held;
    logic [7:0] ascii, press_count;
    logic [6:0] seg_code_lo, seg_code_hi, seg_ascii_lo, seg_ascii_hi, seg_cnt_lo, seg_cnt_hi;

    int total = 0;
    int bad = 0;
    int cnt_n = 0;

    typedef struct packed {
        logic       kh;
        logic [7:0] asc;
        logic [7:0] cnt;
        logic [7:0] hc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic [6:0] x_clo, x_chi, x_alo, x_ahi, x_nlo, x_nhi;

    always #5 clk = ~clk;

    kbd_display dut (
        .clk            (clk),
        .rst            (rst),
        .code_valid_i   (code_valid),
        .code_i         (code),
        .key_held_o     (key_held),
        .ascii_o        (ascii),
        .press_count_o  (press_count),
        .seg_code_lo_o  (seg_code_lo),
        .seg_code_hi_o  (seg_code_hi),
        .seg_ascii_lo_o (seg_ascii_lo),
        .seg_ascii_hi_o (seg_ascii_hi),
        .seg_cnt_lo_o   (seg_cnt_lo),
        .seg_cnt_hi_o   (seg_cnt_hi)
    );

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] tens, units;
        tens  = 4'((n % 100) / 10);
        units = 4'(n % 10);
        return {tens, units};
    endfunction

    always @(posedge clk) begin
        if (!rst || code_valid) begin
            #1;
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_empty t=%0t got=output required=expectation", $time);
            end else begin
                e = sb.pop_front();
                x_chi = e.kh ? glyph(e.hc[7:4]) : 7'h7F;
                x_clo = e.kh ? glyph(e.hc[3:0]) : 7'h7F;
                x_ahi = e.kh ? glyph(e.asc[7:4]) : 7'h7F;
                x_alo = e.kh ? glyph(e.asc[3:0]) : 7'h7F;
                x_nhi = glyph(e.cnt[7:4]);
                x_nlo = glyph(e.cnt[3:0]);
                total += 9;
                if (key_held !== e.kh) begin
                    bad++; $display("FAIL key_held t=%0t got=%b exp=%b", $time, key_held, e.kh);
                end
                if (ascii !== e.asc) begin
                    bad++; $display("FAIL ascii t=%0t got=%h exp=%h", $time, ascii, e.asc);
                end
                if (press_count !== e.cnt) begin
                    bad++;
                    $display("FAIL press_count t=%0t got=%h exp=%h", $time, press_count, e.cnt);
                end
                if (seg_code_hi !== x_chi) begin
                    bad++;
                    $display("FAIL seg_code_hi t=%0t got=%h exp=%h", $time, seg_code_hi, x_chi);
                end
                if (seg_code_lo !== x_clo) begin
                    bad++;
                    $display("FAIL seg_code_lo t=%0t got=%h exp=%h", $time, seg_code_lo, x_clo);
                end
                if (seg_ascii_hi !== x_ahi) begin
                    bad++;
                    $display("FAIL seg_ascii_hi t=%0t got=%h exp=%h", $time, seg_ascii_hi, x_ahi);
                end
                if (seg_ascii_lo !== x_alo) begin
                    bad++;
                    $display("FAIL seg_ascii_lo t=%0t got=%h exp=%h", $time, seg_ascii_lo, x_alo);
                end
                if (seg_cnt_hi !== x_nhi) begin
                    bad++;
                    $display("FAIL seg_cnt_hi t=%0t got=%h exp=%h", $time, seg_cnt_hi, x_nhi);
                end
                if (seg_cnt_lo !== x_nlo) begin
                    bad++;
                    $display("FAIL seg_cnt_lo t=%0t got=%h exp=%h", $time, seg_cnt_lo, x_nlo);
                end
            end
        end
    end

    // Drives one byte for the next edge; strobe stays high so consecutive calls are back-to-back.
    task automatic send(input logic [7:0] c, input bit inc, input bit kh, input logic [7:0] asc,
                        input logic [7:0] hc);
        @(negedge clk);
        code_valid = 1'b1;
        code       = c;
        if (inc) cnt_n++;
        sb.push_back('{kh: kh, asc: asc, cnt: to_bcd(cnt_n), hc: hc});
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        code_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic apply_reset(input bit with_byte);
        @(negedge clk);
        rst        = 1'b0;
        code_valid = with_byte;
        code       = 8'h1C;
        cnt_n      = 0;
        sb.push_back('0);
        @(negedge clk);
        rst        = 1'b1;
        code_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(1'b0);
        idle(10);
        #1;
        total += 4;
        if (key_held !== 1'b0 || press_count !== 8'h00) begin
            bad++; $display("FAIL reset_idle_state got=%b/%h exp=0/00", key_held, press_count);
        end
        if (seg_cnt_lo !== 7'h40 || seg_cnt_hi !== 7'h40) begin
            bad++; $display("FAIL reset_cnt_segs got=%h/%h exp=40/40", seg_cnt_hi, seg_cnt_lo);
        end
        if (seg_code_lo !== 7'h7F || seg_code_hi !== 7'h7F) begin
            bad++; $display("FAIL reset_code_segs got=%h/%h exp=7f/7f", seg_code_hi, seg_code_lo);
        end
        if (seg_ascii_lo !== 7'h7F || seg_ascii_hi !== 7'h7F) begin
            bad++;
            $display("FAIL reset_ascii_segs got=%h/%h exp=7f/7f", seg_ascii_hi, seg_ascii_lo);
        end
    endtask

    task automatic test_typematic();
        apply_reset(1'b0);
        send(8'h1C, 1, 1, 8'h41, 8'h1C);
        send(8'h1C, 0, 1, 8'h41, 8'h1C);
        send(8'h1C, 0, 1, 8'h41, 8'h1C);
        send(8'hF0, 0, 1, 8'h41, 8'h1C);
        send(8'h1C, 0, 0, 8'h00, 8'h00);
        idle(2);
    endtask

    task automatic test_rollover();
        apply_reset(1'b0);
        send(8'h1C, 1, 1, 8'h41, 8'h1C);
        send(8'h32, 1, 1, 8'h42, 8'h32);
        send(8'hF0, 0, 1, 8'h42, 8'h32);
        send(8'h1C, 0, 1, 8'h42, 8'h32);
        send(8'hF0, 0, 1, 8'h42, 8'h32);
        send(8'h32, 0, 0, 8'h00, 8'h00);
        idle(2);
    endtask

    task automatic test_extended();
        apply_reset(1'b0);
        send(8'hE0, 0, 0, 8'h00, 8'h00);
        send(8'h75, 1, 1, 8'h00, 8'h75);
        send(8'h75, 1, 1, 8'h00, 8'h75);
        send(8'hE0, 0, 1, 8'h00, 8'h75);
        send(8'hF0, 0, 1, 8'h00, 8'h75);
        send(8'h75, 0, 1, 8'h00, 8'h75);
        send(8'hF0, 0, 1, 8'h00, 8'h75);
        send(8'h75, 0, 0, 8'h00, 8'h00);
        idle(2);
    endtask

    task automatic test_ignored_and_ascii();
        logic [7:0] keys [5] = '{8'h45, 8'h29, 8'h5A, 8'h1A, 8'h46};
        logic [7:0] chars [5] = '{8'h30, 8'h20, 8'h0D, 8'h5A, 8'h39};
        apply_reset(1'b0);
        send(8'h1C, 1, 1, 8'h41, 8'h1C);
        send(8'h00, 0, 1, 8'h41, 8'h1C);
        send(8'hFA, 0, 1, 8'h41, 8'h1C);
        send(8'hF0, 0, 1, 8'h41, 8'h1C);
        send(8'hAA, 0, 1, 8'h41, 8'h1C);
        send(8'hF0, 0, 1, 8'h41, 8'h1C);
        send(8'h1C, 0, 0, 8'h00, 8'h00);
        // Stray break while idle returns to idle without counting.
        send(8'hF0, 0, 0, 8'h00, 8'h00);
        send(8'h32, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            send(keys[i], 1, 1, chars[i], keys[i]);
            send(8'hF0, 0, 1, chars[i], keys[i]);
            send(keys[i], 0, 0, 8'h00, 8'h00);
        end
        idle(2);
    endtask

    task automatic test_wrap();
        apply_reset(1'b0);
        for (int i = 1; i <= 100; i++) begin
            send(8'h16, 1, 1, 8'h31, 8'h16);
            if (i == 99) begin
                @(posedge clk);
                #2;
                total++;
                if (seg_cnt_hi !== 7'h10 || seg_cnt_lo !== 7'h10) begin
                    bad++;
                    $display("FAIL wrap_99_segs got=%h/%h exp=10/10", seg_cnt_hi, seg_cnt_lo);
                end
            end
            send(8'hF0, 0, 1, 8'h31, 8'h16);
            send(8'h16, 0, 0, 8'h00, 8'h00);
        end
        idle(2);
        #1;
        total++;
        if (press_count !== 8'h00) begin
            bad++; $display("FAIL wrap_final got=%h exp=00", press_count);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(1'b0);
        send(8'h1C, 1, 1, 8'h41, 8'h1C);
        send(8'hF0, 0, 1, 8'h41, 8'h1C);
        apply_reset(1'b0);
        send(8'h1C, 1, 1, 8'h41, 8'h1C);
        idle(1);
        // Reset coincident with a strobe drops the byte.
        apply_reset(1'b1);
        idle(2);
        #1;
        total++;
        if (key_held !== 1'b0 || press_count !== 8'h00) begin
            bad++;
            $display("FAIL reset_drops_byte got=%b/%h exp=0/00", key_held, press_count);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset(1'b0);
        send(8'h1C, 1, 1, 8'h41, 8'h1C);
        send(8'h32, 1, 1, 8'h42, 8'h32);
        send(8'hE0, 0, 1, 8'h42, 8'h32);
        send(8'h32, 1, 1, 8'h00, 8'h32);
        send(8'hE0, 0, 1, 8'h00, 8'h32);
        send(8'hF0, 0, 1, 8'h00, 8'h32);
        send(8'h32, 0, 0, 8'h00, 8'h00);
        send(8'h45, 1, 1, 8'h30, 8'h45);
        idle(2);
    endtask

    initial begin
        test_reset();
        test_typematic();
        test_rollover();
        test_extended();
        test_ignored_and_ascii();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        idle(3);
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kbd_display.md
# kbd_display

Keyboard event tracker and seven-segment display driver. Consumes the PS/2 scan-code byte stream produced by the keyboard controller as one-cycle `code_valid` strobes, and tracks make/break/extended prefixes to decide which key is held. Counts distinct key presses in BCD, translates the held key to ASCII, and drives six active-low seven-segment digits: scan code, ASCII, press count.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- code_valid  in  1  one-cycle strobe, `code` is a new scan-code byte
- code  in  8  scan-code byte (set 2)
- key_held  out  1  a key is currently held
- ascii  out  8  ASCII of held key, 0x00 when none or unmapped
- press_count  out  8  two BCD digits, [7:4] tens, [3:0] units
- seg_code_lo / seg_code_hi  out  7 each  hex of held scan code, low/high nibble
- seg_ascii_lo / seg_ascii_hi  out  7 each  hex of `ascii`
- seg_cnt_lo / seg_cnt_hi  out  7 each  press_count units/tens

## Operation
- Segment encoding:
  - Active-low; bit0 = a … bit6 = g.
  - Standard hex glyphs: 0=0x40, 1=0x79, 2=0x24, 4=0x19, A=0x08, C=0x46.
  - Blank = 0x7F.
- Registers:
  - `state` ∈ {IDLE, HELD, BRK}
  - `ext` flag
  - `held` (9 bits: ext bit + code)
  - `brk_from`: state to return to after a break
  - `press_count`
- Prefix bytes, any state:
  - 0xE0 sets `ext`; state is unchanged.
  - 0xF0 records `brk_from` and moves to BRK. If already in BRK, stays in BRK with `brk_from` unchanged.
- Bytes ignored entirely: 0x00, 0xFA, 0xAA. No state change.
- Normal byte c, with e = `ext`. After consumption, `ext` clears.
  - IDLE: `held` ← {e,c}, go to HELD, count +1.
  - HELD, {e,c} == `held`: typematic repeat. No change, no count.
  - HELD, {e,c} ≠ `held`: rollover. `held` ← {e,c}, count +1.
  - BRK, {e,c} == `held` and `brk_from` = HELD: go to IDLE, key released.
  - BRK, otherwise: return to `brk_from`. Nothing else changes.
- ASCII map, non-extended only; extended keys give 0x00:
  - Letters to uppercase, e.g. 0x1C→0x41, 0x32→0x42.
  - Digit row to 0x30–0x39, e.g. 0x45→0x30, 0x16→0x31.
  - 0x29→0x20, 0x5A→0x0D.
  - All other codes → 0x00.
- Display:
  - While `key_held`=1: code digits show `held[7:0]` and ASCII digits show `ascii`. ASCII digits show 0,0 when ascii=0x00.
  - While `key_held`=0: code and ASCII digits blank.
  - Count digits are never blanked.
- Counter: BCD; units 9→0 carries to tens; 99→00 wraps.

## Timing
- All state, `held`, `ascii` and `press_count` update on the clk edge that samples `code_valid`=1.
- Segment outputs are combinational decodes of those registers, so every output reflects a byte 1 cycle after its strobe.
- Back-to-back strobes on consecutive cycles must all be consumed; there is no backpressure.
- Reset values (rst=0 at an edge):
  - state IDLE, ext 0, held 0, brk_from IDLE
  - key_held 0, ascii 0x00, press_count 0x00
  - seg_code_* and seg_ascii_* = 0x7F; seg_cnt_* = 0x40
- rst=0 overrides a simultaneous `code_valid`; that byte is dropped.
- Reset mid-sequence, e.g. after F0, discards the pending prefix.

## Test plan
- Reset, then idle 10 cycles:
  - key_held=0, press_count=0x00
  - seg_cnt_lo = seg_cnt_hi = 0x40
  - other segments 0x7F
- Bytes 1C, 1C, 1C, F0, 1C:
  - After the first 1C: key_held=1, ascii=0x41, seg_code_hi=0x79, seg_code_lo=0x46, seg_ascii_hi=0x19, seg_ascii_lo=0x79, count=0x01.
  - Repeats leave count at 0x01.
  - After F0 1C: key_held=0, code/ASCII digits 0x7F.
- Rollover with bytes 1C, 32, F0, 1C, F0, 32:
  - count=0x02.
  - After F0 1C: still held 0x32, ascii=0x42.
  - After F0 32: key_held=0.
- Extended, bytes E0, 75 then 75, E0 F0 75, F0 75:
  - E0 75: key_held=1, ascii=0x00, count +1.
  - Plain 75: treated as rollover, count +1.
  - E0 F0 75: no release, since held is non-extended.
  - F0 75: release.
- Wrap: 100 distinct press/release pairs of 0x16 from count 0x00 → count returns to 0x00. At 99, seg_cnt_hi = seg_cnt_lo = 0x10 (glyph 9).
- rst low one cycle between F0 and 1C while 0x1C is held:
  - Reset values restored.
  - The following 1C is a new press: count=0x01, key_held=1.
